// File: rtl/lane_note_if.sv
// Spawn request and renderer query signals shared by the note engine and its
// clients.
// Spawn handshake: spawn_valid/spawn_lane come from the requester. spawn_ready
// is driven combinationally by the engine. A note is accepted on a rising clk
// edge where spawn_valid and spawn_ready are both high. The requester may drop
// or change a request at any time, and the engine never accepts without
// spawn_valid.
// Query port: q_lane/q_slot select a slot. q_valid and q_y follow
// combinationally, and q_y reads 0 for an empty slot.
interface lane_note_if #(
  parameter int LANES = 3,
  parameter int SLOTS = 4,
  parameter int Y_W   = 10
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic              spawn_valid;
  logic [LANE_W-1:0] spawn_lane;
  logic              spawn_ready;
  logic [LANE_W-1:0] q_lane;
  logic [SLOT_W-1:0] q_slot;
  logic              q_valid;
  logic [Y_W-1:0]    q_y;

  modport master (
    output spawn_valid, spawn_lane, q_lane, q_slot,
    input  spawn_ready, q_valid, q_y
  );

  modport slave (
    input  spawn_valid, spawn_lane, q_lane, q_slot,
    output spawn_ready, q_valid, q_y
  );
endinterface

// File: rtl/lane_note_engine.sv
// Note tracking and hit judgement for the rhythm game. The engine holds up to
// SLOTS falling notes per lane and advances them on tick. It judges key presses
// against the hit line and keeps score, combo, miss count and game state.
// Rendering reads notes through the query port of the interface.
module lane_note_engine #(
  parameter int LANES       = 3,
  parameter int SLOTS       = 4,
  parameter int Y_W         = 10,
  parameter int HIT_Y       = 380,
  parameter int PERFECT_WIN = 10,
  parameter int GOOD_WIN    = 30,
  parameter int BOTTOM_Y    = 480,
  parameter int COOLDOWN    = 500000,
  parameter int MAX_MISS    = 8,
  parameter int SCORE_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic [3:0]         step,
  lane_note_if.slave         bus,
  input  logic [LANES-1:0]   KEY,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo,
  output logic [7:0]         max_combo,
  output logic [3:0]         miss_count,
  output logic [LANES-1:0]   hit_pulse,
  output logic               hit_perfect,
  output logic               game_active,
  output logic               game_over,
  output logic [1:0]         state_dbg
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CD_W   = $clog2(COOLDOWN + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2} state_t;

  state_t             state, state_n;
  logic               enter_play;
  logic               play;

  logic [SLOTS-1:0]   slot_v   [LANES];
  logic [SLOTS-1:0]   slot_v_n [LANES];
  logic [Y_W-1:0]     slot_y   [LANES][SLOTS];
  logic [Y_W-1:0]     slot_y_n [LANES][SLOTS];
  logic [CD_W-1:0]    cooldown [LANES];
  logic [CD_W-1:0]    cd_n     [LANES];
  logic [LANES-1:0]   key_prev;
  logic [LANES-1:0]   press;

  logic [LANES-1:0]   hit_n;
  logic               perf_n;
  logic               ghost;
  logic               found;
  int                 best_s;
  logic [Y_W-1:0]     best_y;
  logic [Y_W:0]       ny;
  int                 mult;
  int                 award;
  int                 n_hits;
  int                 n_miss;
  int                 miss_sum;
  int                 combo_sum;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_n;
  logic [7:0]         combo_n;
  logic [7:0]         max_n;
  logic [3:0]         miss_n;
  logic               spawn_ok;

  // Distance of a note from the hit line, in pixels.
  function automatic int dist_to_hit(input logic [Y_W-1:0] y);
    int d;
    d = int'(y) - HIT_Y;
    return (d < 0) ? -d : d;
  endfunction

  assign play        = (state == S_PLAY);
  assign press       = ~KEY & key_prev;
  assign game_active = play;
  assign game_over   = (state == S_OVER);
  assign state_dbg   = state;
  assign bus.spawn_ready = spawn_ok;

  // Game state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next game state. PLAY ends in the cycle the miss count reaches the limit.
  always_comb begin
    state_n    = state;
    enter_play = 1'b0;
    case (state)
      S_IDLE: if (start) begin state_n = S_PLAY; enter_play = 1'b1; end
      S_PLAY: if (miss_sum >= MAX_MISS) state_n = S_OVER;
      S_OVER: if (start) begin state_n = S_PLAY; enter_play = 1'b1; end
      default: state_n = S_IDLE;
    endcase
  end

  // Per-cycle judgement, advance, spawn and counter updates, all based on
  // the slot contents at the start of the cycle.
  always_comb begin
    slot_v_n = slot_v;
    slot_y_n = slot_y;
    cd_n     = cooldown;
    hit_n    = '0;
    perf_n   = 1'b0;
    ghost    = 1'b0;
    found    = 1'b0;
    best_s   = 0;
    best_y   = '0;
    ny       = '0;
    award    = 0;
    n_hits   = 0;
    n_miss   = 0;
    spawn_ok = 1'b0;
    mult     = 1 + int'(combo >> 3);
    if (mult > 4) mult = 4;

    for (int l = 0; l < LANES; l++) begin
      if (cooldown[l] != '0) cd_n[l] = cooldown[l] - 1'b1;
      // The lowest note inside the good window wins. Ties keep the lowest index.
      found  = 1'b0;
      best_s = 0;
      best_y = '0;
      for (int s = 0; s < SLOTS; s++) begin
        if (slot_v[l][s] && (dist_to_hit(slot_y[l][s]) <= GOOD_WIN) &&
            (!found || (slot_y[l][s] > best_y))) begin
          found  = 1'b1;
          best_s = s;
          best_y = slot_y[l][s];
        end
      end
      if (play && press[l] && (cooldown[l] == '0)) begin
        if (found) begin
          hit_n[l]              = 1'b1;
          slot_v_n[l][best_s]   = 1'b0;
          cd_n[l]               = CD_W'(COOLDOWN);
          n_hits                = n_hits + 1;
          if (dist_to_hit(best_y) <= PERFECT_WIN) begin
            perf_n = 1'b1;
            award  = award + 2 * mult;
          end else begin
            award  = award + mult;
          end
        end else begin
          ghost = 1'b1;
        end
      end
      // A note judged as hit this cycle is neither moved nor missed.
      if (play && tick) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (slot_v[l][s] && !(hit_n[l] && (best_s == s))) begin
            ny = {1'b0, slot_y[l][s]} + (Y_W+1)'(step);
            if (int'(ny) > BOTTOM_Y) begin
              slot_v_n[l][s] = 1'b0;
              n_miss         = n_miss + 1;
            end else begin
              slot_y_n[l][s] = ny[Y_W-1:0];
            end
          end
        end
      end
    end

    // Spawn into the lowest slot that was free at the start of the cycle.
    if (play && bus.spawn_valid) begin
      for (int l = 0; l < LANES; l++) begin
        if (bus.spawn_lane == LANE_W'(l)) begin
          for (int s = 0; s < SLOTS; s++) begin
            if (!slot_v[l][s] && !spawn_ok) begin
              spawn_ok       = 1'b1;
              slot_v_n[l][s] = 1'b1;
              slot_y_n[l][s] = '0;
            end
          end
        end
      end
    end

    score_sum = {1'b0, score} + (SCORE_W+1)'(award);
    score_n   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    combo_sum = int'(combo) + n_hits;
    if (combo_sum > 255) combo_sum = 255;
    combo_n   = ((n_miss != 0) || ghost) ? 8'd0 : 8'(combo_sum);
    max_n     = (combo_n > max_combo) ? combo_n : max_combo;

    miss_sum  = int'(miss_count) + n_miss;
    if (miss_sum > 15) miss_sum = 15;
    miss_n    = 4'(miss_sum);
  end

  // Datapath registers. Key history keeps tracking in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v      <= '{default: '0};
      slot_y      <= '{default: '0};
      cooldown    <= '{default: '0};
      key_prev    <= '1;
      score       <= '0;
      combo       <= '0;
      max_combo   <= '0;
      miss_count  <= '0;
      hit_pulse   <= '0;
      hit_perfect <= 1'b0;
    end else begin
      key_prev <= KEY;
      if (enter_play) begin
        slot_v      <= '{default: '0};
        slot_y      <= '{default: '0};
        cooldown    <= '{default: '0};
        score       <= '0;
        combo       <= '0;
        max_combo   <= '0;
        miss_count  <= '0;
        hit_pulse   <= '0;
        hit_perfect <= 1'b0;
      end else begin
        slot_v      <= slot_v_n;
        slot_y      <= slot_y_n;
        cooldown    <= cd_n;
        score       <= score_n;
        combo       <= combo_n;
        max_combo   <= max_n;
        miss_count  <= miss_n;
        hit_pulse   <= hit_n;
        hit_perfect <= perf_n;
      end
    end
  end

  // Renderer query of one slot.
  always_comb begin
    bus.q_valid = 1'b0;
    bus.q_y     = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < SLOTS; s++) begin
        if ((bus.q_lane == LANE_W'(l)) && (bus.q_slot == SLOT_W'(s)) && slot_v[l][s]) begin
          bus.q_valid = 1'b1;
          bus.q_y     = slot_y[l][s];
        end
      end
    end
  end
endmodule

// File: tb/tb_lane_note_engine.sv
// Directed bench for lane_note_engine: one task per scenario, inline checks
// against hand-computed values, and a single summary line at the end.
module tb_lane_note_engine;
  localparam int LANES   = 3;
  localparam int SLOTS   = 4;
  localparam int Y_W     = 10;
  localparam int SCORE_W = 16;
  localparam int CD      = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               tick;
  logic [3:0]         step;
  logic [LANES-1:0]   KEY;
  logic [SCORE_W-1:0] score;
  logic [7:0]         combo;
  logic [7:0]         max_combo;
  logic [3:0]         miss_count;
  logic [LANES-1:0]   hit_pulse;
  logic               hit_perfect;
  logic               game_active;
  logic               game_over;
  logic [1:0]         state_dbg;

  int checks = 0;
  int errors = 0;

  lane_note_if #(.LANES(LANES), .SLOTS(SLOTS), .Y_W(Y_W)) bus ();

  lane_note_engine #(
    .LANES(LANES), .SLOTS(SLOTS), .Y_W(Y_W), .COOLDOWN(CD), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .step(step), .bus(bus),
    .KEY(KEY), .score(score), .combo(combo), .max_combo(max_combo),
    .miss_count(miss_count), .hit_pulse(hit_pulse), .hit_perfect(hit_perfect),
    .game_active(game_active), .game_over(game_over), .state_dbg(state_dbg)
  );

  // Clock and run-time guard.
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout exceeded");
    $fatal(1, "timeout");
  end

  // Driver tasks. Inputs change 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_tick(input int n);
    tick = 1'b1; cyc(n); tick = 1'b0;
  endtask

  task automatic do_spawn(input int lane);
    bus.spawn_valid = 1'b1; bus.spawn_lane = 2'(lane); cyc(1); bus.spawn_valid = 1'b0;
  endtask

  task automatic press_keys(input logic [LANES-1:0] mask);
    KEY = ~mask; cyc(1); KEY = '1;
  endtask

  task automatic q_read(input int lane, input int slot);
    bus.q_lane = 2'(lane); bus.q_slot = 2'(slot); #1;
  endtask

  task automatic round(input logic [LANES-1:0] mask);
    for (int l = 0; l < LANES; l++) if (mask[l]) do_spawn(l);
    do_tick(38);
    press_keys(mask);
  endtask

  task automatic test_reset;
    rst = 1'b1; cyc(2);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_dbg); end
    checks++; if (game_active !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 00", game_active, game_over); end
    checks++; if (score !== 16'd0 || combo !== 8'd0 || miss_count !== 4'd0 || hit_pulse !== 3'b000) begin errors++; $display("FAIL rst_counters got %0d %0d %0d %b exp 0 0 0 000", score, combo, miss_count, hit_pulse); end
    rst = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
    checks++; if (state_dbg !== 2'd1 || game_active !== 1'b1) begin errors++; $display("FAIL start_play got %0d %b exp 1 1", state_dbg, game_active); end
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < SLOTS; s++) begin
        q_read(l, s);
        checks++; if (bus.q_valid !== 1'b0 || bus.q_y !== 10'd0) begin errors++; $display("FAIL empty_slot l%0d s%0d got %b %0d exp 0 0", l, s, bus.q_valid, bus.q_y); end
      end
    end
  endtask

  task automatic test_perfect_hit;
    step = 4'd10;
    do_spawn(1);
    do_tick(38);
    q_read(1, 0);
    checks++; if (bus.q_valid !== 1'b1 || bus.q_y !== 10'd380) begin errors++; $display("FAIL fall_y got %b %0d exp 1 380", bus.q_valid, bus.q_y); end
    press_keys(3'b010);
    checks++; if (hit_pulse !== 3'b010 || hit_perfect !== 1'b1) begin errors++; $display("FAIL perfect_pulse got %b %b exp 010 1", hit_pulse, hit_perfect); end
    checks++; if (score !== 16'd2 || combo !== 8'd1) begin errors++; $display("FAIL perfect_score got %0d %0d exp 2 1", score, combo); end
    q_read(1, 0);
    checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL perfect_freed got %b exp 0", bus.q_valid); end
    cyc(1);
    checks++; if (hit_pulse !== 3'b000) begin errors++; $display("FAIL pulse_width got %b exp 000", hit_pulse); end
  endtask

  task automatic test_good_and_cooldown;
    do_spawn(0);
    do_tick(2);
    do_spawn(0);
    do_tick(34);
    press_keys(3'b001);
    checks++; if (hit_pulse !== 3'b001 || hit_perfect !== 1'b0) begin errors++; $display("FAIL good_pulse got %b %b exp 001 0", hit_pulse, hit_perfect); end
    checks++; if (score !== 16'd3 || combo !== 8'd2) begin errors++; $display("FAIL good_score got %0d %0d exp 3 2", score, combo); end
    do_tick(4);
    press_keys(3'b001);
    checks++; if (hit_pulse !== 3'b000 || score !== 16'd3 || combo !== 8'd2) begin errors++; $display("FAIL cooldown_ignore got %b %0d %0d exp 000 3 2", hit_pulse, score, combo); end
    q_read(0, 1);
    checks++; if (bus.q_valid !== 1'b1 || bus.q_y !== 10'd380) begin errors++; $display("FAIL cooldown_note got %b %0d exp 1 380", bus.q_valid, bus.q_y); end
    cyc(16);
    press_keys(3'b001);
    checks++; if (hit_pulse !== 3'b001 || hit_perfect !== 1'b1 || score !== 16'd5 || combo !== 8'd3) begin errors++; $display("FAIL after_cooldown got %b %b %0d %0d exp 001 1 5 3", hit_pulse, hit_perfect, score, combo); end
  endtask

  task automatic test_full_lane_and_miss;
    do_spawn(2); do_tick(1);
    do_spawn(2); do_tick(1);
    do_spawn(2); do_tick(1);
    do_spawn(2);
    bus.spawn_valid = 1'b1; bus.spawn_lane = 2'd2; #1;
    checks++; if (bus.spawn_ready !== 1'b0) begin errors++; $display("FAIL full_lane_ready got %b exp 0", bus.spawn_ready); end
    bus.spawn_valid = 1'b0;
    do_tick(45);
    q_read(2, 0);
    checks++; if (bus.q_valid !== 1'b1 || bus.q_y !== 10'd480 || miss_count !== 4'd0) begin errors++; $display("FAIL bottom_edge got %b %0d %0d exp 1 480 0", bus.q_valid, bus.q_y, miss_count); end
    tick = 1'b1; bus.spawn_valid = 1'b1; bus.spawn_lane = 2'd2; #1;
    checks++; if (bus.spawn_ready !== 1'b0) begin errors++; $display("FAIL same_cycle_reuse got %b exp 0", bus.spawn_ready); end
    cyc(1); tick = 1'b0;
    checks++; if (miss_count !== 4'd1 || combo !== 8'd0 || max_combo !== 8'd3) begin errors++; $display("FAIL first_miss got %0d %0d %0d exp 1 0 3", miss_count, combo, max_combo); end
    q_read(2, 0);
    checks++; if (bus.q_valid !== 1'b0 || bus.spawn_ready !== 1'b1) begin errors++; $display("FAIL miss_freed got %b %b exp 0 1", bus.q_valid, bus.spawn_ready); end
    cyc(1); bus.spawn_valid = 1'b0;
    q_read(2, 0);
    checks++; if (bus.q_valid !== 1'b1 || bus.q_y !== 10'd0) begin errors++; $display("FAIL respawn got %b %0d exp 1 0", bus.q_valid, bus.q_y); end
    do_tick(49);
    checks++; if (miss_count !== 4'd5 || game_active !== 1'b1) begin errors++; $display("FAIL drain_misses got %0d %b exp 5 1", miss_count, game_active); end
  endtask

  task automatic test_combo_multiplier;
    round(3'b111);
    checks++; if (hit_pulse !== 3'b111 || score !== 16'd11 || combo !== 8'd3) begin errors++; $display("FAIL triple_hit got %b %0d %0d exp 111 11 3", hit_pulse, score, combo); end
    round(3'b111);
    checks++; if (score !== 16'd17 || combo !== 8'd6) begin errors++; $display("FAIL round2 got %0d %0d exp 17 6", score, combo); end
    round(3'b011);
    checks++; if (hit_pulse !== 3'b011 || score !== 16'd21 || combo !== 8'd8) begin errors++; $display("FAIL round3 got %b %0d %0d exp 011 21 8", hit_pulse, score, combo); end
    round(3'b001);
    checks++; if (score !== 16'd25 || combo !== 8'd9 || max_combo !== 8'd9) begin errors++; $display("FAIL mult2 got %0d %0d %0d exp 25 9 9", score, combo, max_combo); end
    press_keys(3'b010);
    checks++; if (combo !== 8'd0 || miss_count !== 4'd5 || max_combo !== 8'd9 || hit_pulse !== 3'b000 || score !== 16'd25) begin errors++; $display("FAIL ghost got %0d %0d %0d %b %0d exp 0 5 9 000 25", combo, miss_count, max_combo, hit_pulse, score); end
  endtask

  task automatic test_game_over;
    do_spawn(0);
    do_spawn(1);
    do_tick(1);
    do_spawn(2);
    do_tick(48);
    checks++; if (miss_count !== 4'd7 || game_over !== 1'b0) begin errors++; $display("FAIL double_miss got %0d %b exp 7 0", miss_count, game_over); end
    do_tick(1);
    checks++; if (miss_count !== 4'd8 || game_over !== 1'b1 || game_active !== 1'b0 || state_dbg !== 2'd2) begin errors++; $display("FAIL over got %0d %b %b %0d exp 8 1 0 2", miss_count, game_over, game_active, state_dbg); end
    bus.spawn_valid = 1'b1; bus.spawn_lane = 2'd0; #1;
    checks++; if (bus.spawn_ready !== 1'b0) begin errors++; $display("FAIL over_spawn got %b exp 0", bus.spawn_ready); end
    cyc(1); bus.spawn_valid = 1'b0;
    tick = 1'b1; press_keys(3'b111); tick = 1'b0;
    checks++; if (hit_pulse !== 3'b000 || score !== 16'd25 || miss_count !== 4'd8 || combo !== 8'd0) begin errors++; $display("FAIL over_ignore got %b %0d %0d %0d exp 000 25 8 0", hit_pulse, score, miss_count, combo); end
    start = 1'b1; cyc(1); start = 1'b0;
    checks++; if (game_active !== 1'b1 || game_over !== 1'b0 || score !== 16'd0 || combo !== 8'd0 || max_combo !== 8'd0 || miss_count !== 4'd0) begin errors++; $display("FAIL restart got %b %b %0d %0d %0d %0d exp 1 0 0 0 0 0", game_active, game_over, score, combo, max_combo, miss_count); end
    q_read(2, 0);
    checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL restart_slots got %b exp 0", bus.q_valid); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tick = 1'b0; step = 4'd0; KEY = '1;
    bus.spawn_valid = 1'b0; bus.spawn_lane = '0; bus.q_lane = '0; bus.q_slot = '0;
    #1;
    test_reset;
    test_perfect_hit;
    test_good_and_cooldown;
    test_full_lane_and_miss;
    test_combo_multiplier;
    test_game_over;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lane_note_engine.md
Name: lane_note_engine

Overview:
- Parametrised note-tracking and judgement engine for the rhythm game. Successor to the single-note, 3-column display game logic.
- Tracks up to SLOTS falling notes in each of LANES lanes and advances them on a speed tick.
- Judges key presses against a hit line, and keeps score, combo with multiplier, miss count and game state.
- Exposes a per-slot read port so the VGA renderer can draw every active note; the block itself does no pixel generation.

Parameters:
- LANES, 3, number of note lanes / keys (1..8)
- SLOTS, 4, concurrent notes per lane (1..8)
- Y_W, 10, note Y coordinate width
- HIT_Y, 380, Y of the hit line
- PERFECT_WIN, 10, |y-HIT_Y| <= this gives perfect
- GOOD_WIN, 30, |y-HIT_Y| <= this gives good
- BOTTOM_Y, 480, a note whose y exceeds this is missed
- COOLDOWN, 500000, per-lane lockout cycles after a hit
- MAX_MISS, 8, miss count that ends the game
- SCORE_W, 16, score width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new game from IDLE or OVER
- tick  in  1  one-cycle note-advance pulse from the speed divider
- step  in  4  pixels added to every active note per tick
- spawn_valid  in  1  request a new note
- spawn_lane  in  clog2(LANES)  lane for the new note
- spawn_ready  out  1  spawn accepted this cycle (combinational)
- KEY  in  LANES  active-low lane buttons, already synchronised
- q_lane  in  clog2(LANES)  renderer query lane
- q_slot  in  clog2(SLOTS)  renderer query slot
- q_valid  out  1  queried slot holds a note (combinational)
- q_y  out  Y_W  queried note Y (combinational)
- score  out  SCORE_W  accumulated score, saturating
- combo  out  8  current consecutive-hit count, saturating at 255
- max_combo  out  8  best combo this game
- miss_count  out  4  misses this game
- hit_pulse  out  LANES  one-cycle pulse per lane on a judged hit
- hit_perfect  out  1  high with hit_pulse if any hit this cycle was perfect
- game_active  out  1  high in PLAY
- game_over  out  1  high in OVER

Behaviour:
- Reset: state IDLE; all slots invalid; score, combo, max_combo, miss_count = 0; hit_pulse = 0; cooldowns = 0; key history = all ones.
- Reset mid-game aborts immediately; all state is lost.
- State machine:
  - IDLE -> PLAY on start.
  - PLAY -> OVER in the cycle miss_count would become >= MAX_MISS (the count update lands, then OVER).
  - OVER -> PLAY on start.
  - Entering PLAY clears slots, score, combo, max_combo, miss_count and cooldowns.
  - start is ignored in PLAY.
- Press detection: press[i] = ~KEY[i] & key_prev[i]. key_prev updates every cycle in every state.
- Outside PLAY, presses, ticks and spawns have no effect, and spawn_ready = 0.
- Spawn:
  - spawn_ready = PLAY & spawn_valid & (lane has a slot free at cycle start).
  - On accept, the lowest-index free slot becomes valid with y = 0.
  - A slot freed in the same cycle is not reusable until the next cycle.
  - spawn_lane >= LANES gives spawn_ready = 0.
- Judgement, per lane, on a press with that lane's cooldown = 0:
  - Candidate = valid slot with largest pre-tick y satisfying |y-HIT_Y| <= GOOD_WIN; ties go to the lowest index.
  - Candidate found: slot freed, hit_pulse[i] = 1, cooldown = COOLDOWN.
  - Base award = 2 if perfect, else 1.
  - No candidate (ghost press): combo breaks; no miss counted; no cooldown.
  - A press during cooldown is ignored entirely. A nonzero cooldown decrements by 1 per cycle.
- Multiplier = 1 + (combo >> 3), capped at 4, using combo at the start of the cycle.
- Each hit awards base * multiplier. All lanes' awards in one cycle are summed. score saturates at 2^SCORE_W-1.
- Advance:
  - On tick, every valid slot not hit this cycle gets y <= y + step, computed at Y_W+1 bits.
  - If the result > BOTTOM_Y, the slot is freed and counts one miss. Multiple misses in one cycle all count.
  - miss_count saturates at 15.
- Combo update per cycle:
  - Any miss or ghost press: combo = 0.
  - Otherwise: combo = combo + number of hits, saturating at 255.
  - max_combo = max(max_combo, new combo).
- Simultaneous events:
  - Hit, tick and spawn may occur in one cycle. Judgement uses pre-tick positions.
  - A hit note is never also missed.
  - A spawned note is not advanced in its spawn cycle.
- hit_perfect is valid only while |hit_pulse.
- q_y is valid only when q_valid; q_y = 0 when the slot is empty.
- Latency: the spawn, hit and miss effects are visible on registered outputs the cycle after the event.

Test Plan:
- Reset, then start -> state PLAY, game_active = 1; score = 0, combo = 0, miss_count = 0; all q_valid = 0.
- Spawn lane 1; step = 10; 38 ticks -> q_y = 380. Press KEY[1] -> hit_pulse = 3'b010, hit_perfect = 1, score = 2, combo = 1, slot freed.
- Note at y = 360 in lane 0, press KEY[0] -> good, score += 1. Press again within COOLDOWN (a note at 380 present) -> ignored; score and note unchanged.
- Fill lane 2 with SLOTS = 4 notes -> fifth spawn_valid gives spawn_ready = 0. After one note misses past y = 480 -> miss_count = 1, combo = 0, spawn accepted next cycle.
- Build combo = 8, then a perfect hit -> award 4 (multiplier 2). Ghost press on an empty lane -> combo = 0, miss_count unchanged, max_combo = 9.
- Let 8 notes fall past BOTTOM_Y (two in the same tick cycle) -> miss_count = 8, game_over = 1, ticks and keys ignored. start -> PLAY with all counters cleared.
